// File: rtl/fifo_ctrl_pkg.sv
// Shared types and constants for the push-key FIFO controller.
package fifo_ctrl_pkg;

  localparam int unsigned DW_DEF = 24;
  localparam int unsigned KEY_WR = 1;
  localparam int unsigned KEY_RD = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD      = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RELEASE = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/key_conditioner.sv
// Conditions one active-low push-key into a pressed level and a one-cycle press pulse.
// Optional debounce is enabled with FIFO_KEY_CTRL_DEBOUNCE_EN.
module key_conditioner #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press_c,
  output logic level
);

  if (DEB_CYCLES < 2) begin : g_deb_chk
    $error("key_conditioner: DEB_CYCLES must be >= 2");
  end

  logic [1:0] sync_q, sync_d;
  logic       level_q, level_d;
  logic       pressed_raw;

  assign pressed_raw = ~sync_q[1];
  assign level       = level_q;

  // Two-flop synchroniser on the raw key
  always_comb begin
    sync_d = {sync_q[0], key_n};
  end

`ifdef FIFO_KEY_CTRL_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Accept a new level only after it has differed from the accepted one for DEB_CYCLES cycles
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_c = 1'b0;
    if (pressed_raw != level_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES)) begin
        level_d = pressed_raw;
        press_c = pressed_raw;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Debounce counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  // Accept synchroniser output directly
  always_comb begin
    level_d = pressed_raw;
    press_c = pressed_raw & ~level_q;
  end
`endif

  // Synchroniser and accepted-level registers; reset to released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/fifo_key_ctrl.sv
// Push-key to FIFO write/read strobe controller with read-data capture for display.
// Build option: FIFO_KEY_CTRL_DEBOUNCE_EN enables key debounce in key_conditioner.
module fifo_key_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    key,
  input  logic          sw,
  input  logic          fifofull,
  input  logic          notempty,
  input  logic [DW-1:0] rd_data,
  output logic          fifowr,
  output logic          fiford,
  output logic [DW-1:0] wr_data,
  output logic [DW-1:0] disp_data,
  output logic          disp_valid,
  output logic          err_full,
  output logic          err_empty
);

  localparam int unsigned LAT_W = 2;

  if (RD_LAT < 1 || RD_LAT > 3) begin : g_lat_chk
    $error("fifo_key_ctrl: RD_LAT must be 1..3");
  end

  logic wr_ev_c, rd_ev_c, wr_lvl, rd_lvl;

  key_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_key_wr (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_n  (key[KEY_WR]),
    .press_c(wr_ev_c),
    .level  (wr_lvl)
  );

  key_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_key_rd (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_n  (key[KEY_RD]),
    .press_c(rd_ev_c),
    .level  (rd_lvl)
  );

  ctrl_state_t      state_q, state_d;
  logic             fifowr_q, fifowr_d;
  logic             fiford_q, fiford_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [DW-1:0]    disp_data_q, disp_data_d;
  logic             disp_valid_q, disp_valid_d;
  logic             err_full_q, err_full_d;
  logic             err_empty_q, err_empty_d;

  assign fifowr     = fifowr_q;
  assign fiford     = fiford_q;
  assign wr_data    = cnt_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
  assign err_full   = err_full_q;
  assign err_empty  = err_empty_q;

  // Next-state and registered-output decode
  always_comb begin
    state_d      = state_q;
    fifowr_d     = 1'b0;
    fiford_d     = 1'b0;
    cnt_d        = cnt_q;
    lat_d        = lat_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = disp_valid_q;
    err_full_d   = err_full_q;
    err_empty_d  = err_empty_q;
    case (state_q)
      ST_IDLE: begin
        if (sw) begin
          if (wr_ev_c) begin
            if (!fifofull) begin
              state_d  = ST_WR;
              fifowr_d = 1'b1;
            end else begin
              err_full_d = 1'b1;
              state_d    = ST_RELEASE;
            end
          end else if (rd_ev_c) begin
            if (notempty) begin
              state_d  = ST_RD;
              fiford_d = 1'b1;
            end else begin
              err_empty_d = 1'b1;
              state_d     = ST_RELEASE;
            end
          end
        end
      end
      ST_WR: begin
        cnt_d      = cnt_q + DW'(1);
        err_full_d = 1'b0;
        state_d    = ST_RELEASE;
      end
      ST_RD: begin
        err_empty_d = 1'b0;
        lat_d       = '0;
        state_d     = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (lat_q == LAT_W'(RD_LAT - 1)) begin
          disp_data_d  = rd_data;
          disp_valid_d = 1'b1;
          state_d      = ST_RELEASE;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (!wr_lvl && !rd_lvl) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      fifowr_q     <= 1'b0;
      fiford_q     <= 1'b0;
      cnt_q        <= '0;
      lat_q        <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      err_full_q   <= 1'b0;
      err_empty_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      fifowr_q     <= fifowr_d;
      fiford_q     <= fiford_d;
      cnt_q        <= cnt_d;
      lat_q        <= lat_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
      err_full_q   <= err_full_d;
      err_empty_q  <= err_empty_d;
    end
  end

endmodule

// File: tb/tb_fifo_key_ctrl.sv
// Directed self-checking bench for fifo_key_ctrl (default parameters).
// Honours FIFO_KEY_CTRL_DEBOUNCE_EN to match the DUT build.
module tb_fifo_key_ctrl;

  localparam int DEB = 16;
`ifdef FIFO_KEY_CTRL_DEBOUNCE_EN
  localparam int EV = DEB + 2;
`else
  localparam int EV = 2;
`endif
  localparam int HOLD = EV + 6;
  localparam int REL  = EV + 6;

  logic        clk, rst_n, sw, fifofull, notempty;
  logic [1:0]  key;
  logic [23:0] rd_data;
  logic        fifowr, fiford, disp_valid, err_full, err_empty;
  logic [23:0] wr_data, disp_data;

  int errors = 0;
  int checks = 0;

  int          step_idx, wr_seen, rd_seen, first_wr_at, first_rd_at, both_hi;
  logic [23:0] last_wr_data;
  logic [23:0] exp_cnt;

  fifo_key_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key       (key),
    .sw        (sw),
    .fifofull  (fifofull),
    .notempty  (notempty),
    .rd_data   (rd_data),
    .fifowr    (fifowr),
    .fiford    (fiford),
    .wr_data   (wr_data),
    .disp_data (disp_data),
    .disp_valid(disp_valid),
    .err_full  (err_full),
    .err_empty (err_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr_mon();
    step_idx    = 0;
    wr_seen     = 0;
    rd_seen     = 0;
    first_wr_at = -1;
    first_rd_at = -1;
  endtask

  // Advance to the next falling edge and record strobes
  task automatic tick();
    @(negedge clk);
    step_idx++;
    if (fifowr) begin
      wr_seen++;
      last_wr_data = wr_data;
      if (first_wr_at < 0) first_wr_at = step_idx;
    end
    if (fiford) begin
      rd_seen++;
      if (first_rd_at < 0) first_rd_at = step_idx;
    end
    if (fifowr && fiford) both_hi++;
  endtask

  // Press the keys selected by mask for hold cycles, then release and settle
  task automatic press(input logic [1:0] mask, input int hold);
    clr_mon();
    key = ~mask;
    for (int i = 0; i < hold; i++) tick();
    key = 2'b11;
    for (int i = 0; i < REL; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({fifowr, fiford, disp_valid, err_full, err_empty} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000",
               {fifowr, fiford, disp_valid, err_full, err_empty});
    end
    checks++;
    if ({wr_data, disp_data} !== 48'h0) begin
      errors++;
      $display("FAIL reset_data: got wr=%h disp=%h expected 0", wr_data, disp_data);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_writes();
    for (int p = 0; p < 3; p++) begin
      press(2'b10, HOLD);
      checks++;
      if (wr_seen !== 1) begin
        errors++;
        $display("FAIL write%0d_count: got %0d expected 1", p, wr_seen);
      end
      checks++;
      if (last_wr_data !== exp_cnt) begin
        errors++;
        $display("FAIL write%0d_data: got %h expected %h", p, last_wr_data, exp_cnt);
      end
      if (p == 0) begin
        checks++;
        if (first_wr_at !== EV + 1) begin
          errors++;
          $display("FAIL write_latency: got %0d expected %0d", first_wr_at, EV + 1);
        end
      end
      exp_cnt = exp_cnt + 24'd1;
    end
    checks++;
    if (wr_data !== 24'd3) begin
      errors++;
      $display("FAIL counter_after3: got %h expected 000003", wr_data);
    end
  endtask

  task automatic test_hold();
    press(2'b10, 200);
    checks++;
    if (wr_seen !== 1) begin
      errors++;
      $display("FAIL hold_count: got %0d expected 1", wr_seen);
    end
    exp_cnt = exp_cnt + 24'd1;
`ifdef FIFO_KEY_CTRL_DEBOUNCE_EN
    clr_mon();
    for (int b = 0; b < 5; b++) begin
      key = 2'b01;
      repeat (3) tick();
      key = 2'b11;
      repeat (3) tick();
    end
    key = 2'b01;
    for (int i = 0; i < HOLD; i++) tick();
    key = 2'b11;
    for (int i = 0; i < REL; i++) tick();
    checks++;
    if (wr_seen !== 1) begin
      errors++;
      $display("FAIL bounce_count: got %0d expected 1", wr_seen);
    end
    checks++;
    if (last_wr_data !== exp_cnt) begin
      errors++;
      $display("FAIL bounce_data: got %h expected %h", last_wr_data, exp_cnt);
    end
    exp_cnt = exp_cnt + 24'd1;
`endif
    checks++;
    if (wr_data !== exp_cnt) begin
      errors++;
      $display("FAIL counter_after_hold: got %h expected %h", wr_data, exp_cnt);
    end
  endtask

  task automatic test_full();
    fifofull = 1'b1;
    press(2'b10, HOLD);
    checks++;
    if (wr_seen !== 0 || err_full !== 1'b1) begin
      errors++;
      $display("FAIL full_refuse: got wr=%0d err_full=%b expected wr=0 err_full=1", wr_seen, err_full);
    end
    checks++;
    if (wr_data !== exp_cnt) begin
      errors++;
      $display("FAIL full_counter: got %h expected %h", wr_data, exp_cnt);
    end
    fifofull = 1'b0;
    press(2'b10, HOLD);
    checks++;
    if (wr_seen !== 1 || err_full !== 1'b0 || last_wr_data !== exp_cnt) begin
      errors++;
      $display("FAIL full_recover: got wr=%0d err_full=%b data=%h expected 1 0 %h",
               wr_seen, err_full, last_wr_data, exp_cnt);
    end
    exp_cnt = exp_cnt + 24'd1;
  endtask

  task automatic test_read();
    notempty = 1'b0;
    press(2'b01, HOLD);
    checks++;
    if (rd_seen !== 0 || err_empty !== 1'b1) begin
      errors++;
      $display("FAIL empty_refuse: got rd=%0d err_empty=%b expected rd=0 err_empty=1", rd_seen, err_empty);
    end
    notempty = 1'b1;
    rd_data  = 24'hABCDEF;
    clr_mon();
    key = 2'b10;
    for (int i = 0; i < HOLD + REL; i++) begin
      if (i == HOLD) key = 2'b11;
      tick();
      if (first_rd_at > 0 && step_idx == first_rd_at + 1) begin
        checks++;
        if (disp_valid !== 1'b0) begin
          errors++;
          $display("FAIL disp_early: got valid=%b expected 0", disp_valid);
        end
      end
      if (first_rd_at > 0 && step_idx == first_rd_at + 2) begin
        checks++;
        if (disp_valid !== 1'b1 || disp_data !== 24'hABCDEF) begin
          errors++;
          $display("FAIL disp_capture: got valid=%b data=%h expected 1 abcdef", disp_valid, disp_data);
        end
        rd_data = 24'h123456;
      end
    end
    checks++;
    if (rd_seen !== 1 || first_rd_at !== EV + 1) begin
      errors++;
      $display("FAIL read_strobe: got count=%0d at=%0d expected 1 at %0d", rd_seen, first_rd_at, EV + 1);
    end
    checks++;
    if (err_empty !== 1'b0 || disp_data !== 24'hABCDEF || wr_data !== exp_cnt) begin
      errors++;
      $display("FAIL read_after: got err_empty=%b disp=%h wr=%h expected 0 abcdef %h",
               err_empty, disp_data, wr_data, exp_cnt);
    end
  endtask

  task automatic test_both_keys();
    notempty = 1'b1;
    press(2'b11, HOLD);
    checks++;
    if (wr_seen !== 1 || rd_seen !== 0 || last_wr_data !== exp_cnt) begin
      errors++;
      $display("FAIL both_keys: got wr=%0d rd=%0d data=%h expected 1 0 %h",
               wr_seen, rd_seen, last_wr_data, exp_cnt);
    end
    exp_cnt = exp_cnt + 24'd1;
  endtask

  task automatic test_paused();
    fifofull = 1'b1;
    press(2'b10, HOLD);
    fifofull = 1'b0;
    notempty = 1'b0;
    sw       = 1'b0;
    press(2'b10, HOLD);
    checks++;
    if (wr_seen !== 0 || err_full !== 1'b1 || wr_data !== exp_cnt) begin
      errors++;
      $display("FAIL paused_write: got wr=%0d err_full=%b data=%h expected 0 1 %h",
               wr_seen, err_full, wr_data, exp_cnt);
    end
    press(2'b01, HOLD);
    checks++;
    if (rd_seen !== 0 || err_empty !== 1'b0) begin
      errors++;
      $display("FAIL paused_read: got rd=%0d err_empty=%b expected 0 0", rd_seen, err_empty);
    end
    sw = 1'b1;
  endtask

  task automatic test_reset_mid_wr();
    clr_mon();
    key = 2'b01;
    for (int i = 0; i < EV + 10 && wr_seen == 0; i++) tick();
    checks++;
    if (wr_seen !== 1 || err_full !== 1'b1) begin
      errors++;
      $display("FAIL midwr_setup: got wr=%0d err_full=%b expected 1 1", wr_seen, err_full);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({fifowr, fiford, disp_valid, err_full, err_empty} !== 5'b0 || wr_data !== 24'h0) begin
      errors++;
      $display("FAIL midwr_reset: got flags=%b wr=%h expected 00000 000000",
               {fifowr, fiford, disp_valid, err_full, err_empty}, wr_data);
    end
    key = 2'b11;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clr_mon();
    for (int i = 0; i < REL; i++) tick();
    checks++;
    if (wr_seen !== 0 || disp_data !== 24'h0) begin
      errors++;
      $display("FAIL post_reset_idle: got wr=%0d disp=%h expected 0 000000", wr_seen, disp_data);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    key      = 2'b11;
    sw       = 1'b1;
    fifofull = 1'b0;
    notempty = 1'b0;
    rd_data  = 24'h0;
    exp_cnt  = 24'h0;
    both_hi  = 0;
    last_wr_data = 24'h0;
    clr_mon();
    test_reset();
    test_writes();
    test_hold();
    test_full();
    test_read();
    test_both_keys();
    test_paused();
    checks++;
    if (both_hi !== 0) begin
      errors++;
      $display("FAIL strobe_overlap: got %0d expected 0", both_hi);
    end
    test_reset_mid_wr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
